// File: rtl/cover_pkg.sv
// Purpose: shared constants, FSM state type and index split helpers for the toggle-coverage collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cover_pkg;

  localparam int COVER_TOTAL = 8065;
  localparam int IDX_W       = $clog2(COVER_TOTAL);
  localparam int WORD_W      = 64;
  localparam int NUM_WORDS   = (COVER_TOTAL + WORD_W - 1) / WORD_W;
  localparam int WPTR_W      = $clog2(NUM_WORDS);
  localparam int BIT_W       = $clog2(WORD_W);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Bitmap word holding a given cover index.
  function automatic logic [WPTR_W-1:0] word_of(input logic [IDX_W-1:0] idx);
    return WPTR_W'(idx / IDX_W'(WORD_W));
  endfunction

  // Bit position of a cover index inside its bitmap word.
  function automatic logic [BIT_W-1:0] bit_of(input logic [IDX_W-1:0] idx);
    return BIT_W'(idx % IDX_W'(WORD_W));
  endfunction

endpackage

// File: rtl/cover_idx_fifo.sv
// Purpose: small synchronous FIFO of cover indices with flush.
// Latency: a push is visible at the head one cycle later when the FIFO was empty.
// Backpressure: pushes while full and pops while empty are ignored; flush beats push/pop.
module cover_idx_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit tells full apart from empty when the address bits match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush discards every queued entry at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only visible through non-empty pointers.
  always_ff @(posedge clock) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/cover_toggle_collector.sv
// Purpose: records cover-point hits in a bitmap, streams first-time hits and counts covered points.
// Latency: new hit appears on the output one cycle after acceptance; clear takes NUM_WORDS cycles.
// Backpressure: in_ready drops while the new-hit queue is full or a clear is in progress.
module cover_toggle_collector
  import cover_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_index,
  output logic             in_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index,
  input  logic             out_ready,
  input  logic             clear_req,
  output logic             clear_done,
  output logic [IDX_W:0]   covered_count,
  output logic             err_range
);

  state_t            r_state;
  logic [WPTR_W-1:0] r_wptr;
  logic              r_clear_done;
  logic [IDX_W:0]    r_count;
  logic              r_err;
  logic [WORD_W-1:0] r_bitmap [NUM_WORDS];

  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_accept;
  logic              w_in_range;
  logic [WPTR_W-1:0] w_word;
  logic [BIT_W-1:0]  w_bit;
  logic              w_hit_bit;
  logic              w_new_hit;
  logic              w_bad_hit;
  logic              w_start_clear;
  logic              w_pop;

  assign in_ready      = (r_state == RUN) && !w_fifo_full;
  assign w_accept      = in_valid && in_ready;
  assign w_in_range    = (in_index < IDX_W'(COVER_TOTAL));
  // Out-of-range indices are steered to word 0 so the lookup never leaves the array.
  assign w_word        = w_in_range ? word_of(in_index) : '0;
  assign w_bit         = bit_of(in_index);
  assign w_hit_bit     = r_bitmap[w_word][w_bit];
  assign w_start_clear = (r_state == RUN) && clear_req;
  // A clear in the same cycle discards the hit entirely.
  assign w_new_hit     = w_accept && !clear_req && w_in_range && !w_hit_bit;
  assign w_bad_hit     = w_accept && !clear_req && !w_in_range;
  assign out_valid     = !w_fifo_empty;
  assign w_pop         = out_valid && out_ready;

  assign clear_done    = r_clear_done;
  assign covered_count = r_count;
  assign err_range     = r_err;

  cover_idx_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_new_hit),
    .i_push_dat (in_index),
    .i_pop      (w_pop),
    .i_flush    (w_start_clear),
    .o_head     (out_index),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  // RUN/CLEAR sequencing with registered count, error flag and clear_done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_wptr       <= '0;
      r_clear_done <= 1'b0;
      r_count      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (clear_req) begin
            r_state      <= CLEAR;
            r_wptr       <= '0;
            r_count      <= '0;
            r_err        <= 1'b0;
            r_clear_done <= (NUM_WORDS == 1);
          end else begin
            r_clear_done <= 1'b0;
            if (w_new_hit) r_count <= r_count + 1'b1;
            if (w_bad_hit) r_err   <= 1'b1;
          end
        end
        CLEAR: begin
          // clear_done is raised one edge early so it is high during the last word's cycle.
          if (r_wptr == WPTR_W'(NUM_WORDS - 1)) begin
            r_state      <= RUN;
            r_clear_done <= 1'b0;
          end else begin
            r_wptr       <= r_wptr + 1'b1;
            r_clear_done <= (r_wptr == WPTR_W'(NUM_WORDS - 2));
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Bitmap: one word zeroed per CLEAR cycle, otherwise set the bit of each new hit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WORDS; i++) r_bitmap[i] <= '0;
    end else if (r_state == CLEAR) begin
      r_bitmap[r_wptr] <= '0;
    end else if (w_new_hit) begin
      r_bitmap[w_word][w_bit] <= 1'b1;
    end
  end

endmodule
